// File: rtl/pe_bus_pkg.sv
// Shared types and defaults for the PE memory-bus arbiter.
package pe_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    localparam int DEFAULT_NUM_PE  = 4;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    // Timer width able to hold every value up to and including the timeout.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pe_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_PE = 4,
    parameter int PTR_W  = $clog2(NUM_PE)
) (
    input  logic [NUM_PE-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_PE-1:0] gnt,
    output logic [PTR_W-1:0]  idx,
    output logic              any
);

    logic [2*NUM_PE-1:0] req_dbl;
    logic [NUM_PE-1:0]   req_rot;
    logic [PTR_W-1:0]    offset;
    logic [PTR_W:0]      idx_sum;

    // Rotating by ptr puts the highest-priority requester at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[{1'b0, ptr} +: NUM_PE];

    always_comb begin
        offset = '0;
        any    = 1'b0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = PTR_W'(k);
                any    = 1'b1;
            end
        end
    end

    assign idx_sum = {1'b0, offset} + {1'b0, ptr};
    assign idx     = (idx_sum >= (PTR_W+1)'(NUM_PE)) ?
                     PTR_W'(idx_sum - (PTR_W+1)'(NUM_PE)) : idx_sum[PTR_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_gnt
            assign gnt[gi] = any && (idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between NUM_PE processing elements,
// with a per-transaction ack timeout.
module pe_mem_arbiter
    import pe_bus_pkg::*;
#(
    parameter int NUM_PE  = DEFAULT_NUM_PE,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PE-1:0]        pe_read,
    input  logic [NUM_PE-1:0]        pe_write,
    input  logic [NUM_PE*DATA_W-1:0] pe_addr,
    input  logic [NUM_PE*DATA_W-1:0] pe_wdata,
    output logic [NUM_PE-1:0]        pe_grant,
    output logic [NUM_PE-1:0]        pe_done,
    output logic                     pe_err,
    output logic [DATA_W-1:0]        pe_rdata,
    output logic                     bus_read,
    output logic                     bus_write,
    output logic [DATA_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_ack,
    input  logic [DATA_W-1:0]        bus_rdata
);

    localparam int PTR_W   = $clog2(NUM_PE);
    localparam int TIMER_W = timer_width(TIMEOUT);

    arb_state_t         state_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   owner_reg;
    logic [PTR_W-1:0]   ptr_next;
    logic [TIMER_W-1:0] timer_reg;

    logic [NUM_PE-1:0]  req;
    logic [NUM_PE-1:0]  pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    logic [DATA_W-1:0]  addr_arr  [NUM_PE];
    logic [DATA_W-1:0]  wdata_arr [NUM_PE];

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_slice
            assign addr_arr[gi]  = pe_addr[gi*DATA_W +: DATA_W];
            assign wdata_arr[gi] = pe_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign req = pe_read | pe_write;

    rr_pick #(
        .NUM_PE (NUM_PE),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The finished owner drops to lowest priority for the next round.
    assign ptr_next = (owner_reg == PTR_W'(NUM_PE - 1)) ? '0 : owner_reg + PTR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            timer_reg <= '0;
            pe_grant  <= '0;
            pe_done   <= '0;
            pe_err    <= 1'b0;
            pe_rdata  <= '0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        owner_reg <= pick_idx;
                        pe_grant  <= pick_gnt;
                        bus_addr  <= addr_arr[pick_idx];
                        bus_wdata <= wdata_arr[pick_idx];
                        // A PE raising both strobes is served as a write.
                        bus_write <= pe_write[pick_idx];
                        bus_read  <= ~pe_write[pick_idx];
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // Ack takes precedence over an expiry in the same cycle.
                    if (bus_ack || (timer_reg == TIMER_W'(TIMEOUT - 1))) begin
                        if (bus_ack && bus_read) begin
                            pe_rdata <= bus_rdata;
                        end
                        pe_err    <= ~bus_ack;
                        pe_done   <= pe_grant;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                DONE: begin
                    pe_done   <= '0;
                    pe_err    <= 1'b0;
                    pe_grant  <= '0;
                    ptr_reg   <= ptr_next;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Scenario bench for pe_mem_arbiter with a completion scoreboard.
module tb_pe_mem_arbiter;

    localparam int NUM_PE  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_PE-1:0]        pe_read = '0;
    logic [NUM_PE-1:0]        pe_write = '0;
    logic [NUM_PE*DATA_W-1:0] pe_addr = '0;
    logic [NUM_PE*DATA_W-1:0] pe_wdata = '0;
    logic [NUM_PE-1:0]        pe_grant;
    logic [NUM_PE-1:0]        pe_done;
    logic                     pe_err;
    logic [DATA_W-1:0]        pe_rdata;
    logic                     bus_read;
    logic                     bus_write;
    logic [DATA_W-1:0]        bus_addr;
    logic [DATA_W-1:0]        bus_wdata;
    logic                     bus_ack = 1'b0;
    logic [DATA_W-1:0]        bus_rdata = '0;

    typedef struct {
        logic [NUM_PE-1:0] done;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model_rdata = '0;
    int                n_checks = 0;
    int                n_fail = 0;

    pe_mem_arbiter #(
        .NUM_PE  (NUM_PE),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pe_read   (pe_read),
        .pe_write  (pe_write),
        .pe_addr   (pe_addr),
        .pe_wdata  (pe_wdata),
        .pe_grant  (pe_grant),
        .pe_done   (pe_done),
        .pe_err    (pe_err),
        .pe_rdata  (pe_rdata),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Scoreboard: every completion is popped against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && pe_done !== '0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got pe_done=%b, required none", pe_done);
            end else begin
                e = exp_q.pop_front();
                if (pe_done !== e.done || pe_err !== e.err || pe_rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL done_result: got done=%b err=%b rdata=%h, required done=%b err=%b rdata=%h",
                             pe_done, pe_err, pe_rdata, e.done, e.err, e.rdata);
                end else begin
                    $display("done pe=%b err=%b rdata=%h", pe_done, pe_err, pe_rdata);
                end
            end
        end
        if (!reset && pe_err === 1'b1 && pe_done === '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL err_alone: got pe_err=1 with pe_done=0, required coincident");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_rdata = '0;
        tick();
    endtask

    task automatic set_pe(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
        pe_addr[i*DATA_W +: DATA_W]  = a;
        pe_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_exp(input int pe, input logic err, input logic is_read, input logic [DATA_W-1:0] rd);
        exp_t e;
        if (is_read && !err) model_rdata = rd;
        e.done  = NUM_PE'(1) << pe;
        e.err   = err;
        e.rdata = model_rdata;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d completions outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({pe_grant, pe_done, pe_err, bus_read, bus_write} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b done=%b err=%b rd=%b wr=%b, required 0",
                     pe_grant, pe_done, pe_err, bus_read, bus_write);
        end
        n_checks++;
        if (pe_rdata !== '0 || bus_addr !== '0 || bus_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, required 0", pe_rdata, bus_addr, bus_wdata);
        end
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (pe_grant !== '0 || bus_read !== 1'b0 || bus_write !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: got grant=%b rd=%b wr=%b, required 0", pe_grant, bus_read, bus_write);
        end
        $display("reset checked");
    endtask

    task automatic test_single_read();
        int  strobe_n = 0;
        bit  seen = 0;
        set_pe(2, 32'h100, 32'h0);
        pe_read = 4'b0100;
        push_exp(2, 1'b0, 1'b1, 32'hDEAD_BEEF);
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            bus_ack = 1'b0;
            if (bus_read) begin
                strobe_n++;
                if (strobe_n == 1) begin
                    n_checks++;
                    if (bus_addr !== 32'h100 || pe_grant !== 4'b0100) begin
                        n_fail++;
                        $display("FAIL read_issue: got addr=%h grant=%b, required 00000100 0100", bus_addr, pe_grant);
                    end
                end
                if (strobe_n == 4) begin
                    bus_ack   = 1'b1;
                    bus_rdata = 32'hDEAD_BEEF;
                end
            end
            if (pe_done !== '0) begin
                seen = 1;
                pe_read = '0;
                n_checks++;
                if (pe_rdata !== 32'hDEAD_BEEF || bus_read !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_done: got rdata=%h rd=%b, required deadbeef 0", pe_rdata, bus_read);
                end
            end
        end
        n_checks++;
        if (!seen || strobe_n != 4) begin
            n_fail++;
            $display("FAIL read_strobe_len: got %0d cycles done=%0d, required 4 cycles done=1", strobe_n, seen);
        end
        $display("single read: strobe cycles=%0d", strobe_n);
        check_drained("single_read");
    endtask

    task automatic test_all_writes();
        int                k = 0;
        int                last_c = -1;
        logic [NUM_PE-1:0] prev_grant = '0;
        do_reset();
        for (int i = 0; i < NUM_PE; i++) begin
            set_pe(i, 32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i));
            push_exp(i, 1'b0, 1'b0, '0);
        end
        pe_write = '1;
        for (int c = 1; c <= 60 && pe_write != '0; c++) begin
            tick();
            bus_ack = bus_write;
            if (pe_grant !== '0 && prev_grant === '0) begin
                n_checks++;
                if (pe_grant !== (NUM_PE'(1) << k) || bus_write !== 1'b1 ||
                    bus_wdata !== 32'hA000_0000 + 32'(k) || bus_addr !== 32'h200 + 32'(k * 4)) begin
                    n_fail++;
                    $display("FAIL write_issue%0d: got grant=%b wr=%b wdata=%h addr=%h, required grant=%b wr=1 wdata=%h addr=%h",
                             k, pe_grant, bus_write, bus_wdata, bus_addr, NUM_PE'(1) << k,
                             32'hA000_0000 + 32'(k), 32'h200 + 32'(k * 4));
                end
                k++;
            end
            if (pe_done !== '0) begin
                pe_write = pe_write & ~pe_done;
                last_c = c;
            end
            prev_grant = pe_grant;
        end
        bus_ack = 1'b0;
        n_checks++;
        if (k != NUM_PE || last_c != 15) begin
            n_fail++;
            $display("FAIL write_burst: got grants=%0d last_done_cycle=%0d, required 4 and 15", k, last_c);
        end
        $display("all writes: grants=%0d last done cycle=%0d", k, last_c);
        pe_write = '0;
        check_drained("all_writes");
    endtask

    task automatic test_fairness();
        int n_done = 0;
        int pe3_pos = -1;
        do_reset();
        set_pe(0, 32'h300, 32'h0);
        set_pe(3, 32'h33C, 32'h0);
        push_exp(0, 1'b0, 1'b1, 32'h3000_0000);
        push_exp(3, 1'b0, 1'b1, 32'h3000_0001);
        push_exp(0, 1'b0, 1'b1, 32'h3000_0002);
        pe_read = 4'b1001;
        for (int c = 0; c < 60 && n_done < 3; c++) begin
            tick();
            bus_ack   = bus_read;
            bus_rdata = 32'h3000_0000 + 32'(n_done);
            if (pe_done !== '0) begin
                if (pe_done[3]) begin
                    pe3_pos = n_done;
                    pe_read[3] = 1'b0;
                end
                n_done++;
                if (n_done == 3) pe_read = '0;
            end
        end
        bus_ack = 1'b0;
        n_checks++;
        if (pe3_pos < 0 || pe3_pos > 1) begin
            n_fail++;
            $display("FAIL fairness: got PE3 served at position %0d, required 1", pe3_pos);
        end
        $display("fairness: PE3 position=%0d", pe3_pos);
        check_drained("fairness");
    endtask

    task automatic test_timeout();
        int n_rd = 0;
        int n_done = 0;
        set_pe(1, 32'h400, 32'h0);
        set_pe(2, 32'h480, 32'h77);
        push_exp(1, 1'b1, 1'b1, '0);
        push_exp(2, 1'b0, 1'b0, '0);
        pe_read  = 4'b0010;
        pe_write = 4'b0100;
        for (int c = 0; c < 80 && n_done < 2; c++) begin
            tick();
            bus_ack = bus_write;
            if (bus_read) n_rd++;
            if (pe_done !== '0) begin
                pe_read  = pe_read & ~pe_done;
                pe_write = pe_write & ~pe_done;
                n_done++;
            end
        end
        bus_ack = 1'b0;
        n_checks++;
        if (n_rd != TIMEOUT + 1 || n_done != 2) begin
            n_fail++;
            $display("FAIL timeout_len: got read strobe %0d cycles, %0d dones, required %0d and 2", n_rd, n_done, TIMEOUT + 1);
        end
        $display("timeout: read strobe cycles=%0d", n_rd);
        check_drained("timeout");
    endtask

    task automatic test_ack_last_and_both();
        int  n_rd = 0;
        int  n_wr = 0;
        bit  seen = 0;
        set_pe(3, 32'h500, 32'h0);
        push_exp(3, 1'b0, 1'b1, 32'h5555_AAAA);
        pe_read = 4'b1000;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            bus_ack = 1'b0;
            if (bus_read) begin
                n_rd++;
                if (n_rd == TIMEOUT + 1) begin
                    bus_ack   = 1'b1;
                    bus_rdata = 32'h5555_AAAA;
                end
            end
            if (pe_done !== '0) begin
                seen = 1;
                pe_read = '0;
            end
        end
        bus_ack = 1'b0;
        check_drained("ack_last");

        set_pe(1, 32'h510, 32'h1111_2222);
        push_exp(1, 1'b0, 1'b0, '0);
        pe_read  = 4'b0010;
        pe_write = 4'b0010;
        n_rd = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            bus_ack = bus_read | bus_write;
            if (bus_read) n_rd++;
            if (bus_write) begin
                n_wr++;
                if (n_wr == 1) begin
                    n_checks++;
                    if (bus_wdata !== 32'h1111_2222 || bus_addr !== 32'h510) begin
                        n_fail++;
                        $display("FAIL both_issue: got wdata=%h addr=%h, required 11112222 00000510", bus_wdata, bus_addr);
                    end
                end
            end
            if (pe_done !== '0) begin
                seen = 1;
                pe_read  = '0;
                pe_write = '0;
            end
        end
        bus_ack = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (n_rd != 0 || n_wr != 2 || pe_grant !== '0 || bus_read !== 1'b0) begin
            n_fail++;
            $display("FAIL both_as_write: got rd_cycles=%0d wr_cycles=%0d grant=%b, required 0 2 0000", n_rd, n_wr, pe_grant);
        end
        $display("read+write on PE1: write cycles=%0d read cycles=%0d", n_wr, n_rd);
        check_drained("both");
    endtask

    task automatic test_reset_mid_wait();
        int n_rd = 0;
        int n_done = 0;
        set_pe(0, 32'h600, 32'h0);
        pe_read = 4'b0001;
        for (int c = 0; c < 20 && n_rd < 3; c++) begin
            tick();
            if (bus_read) n_rd++;
        end
        pe_read = 4'b1010;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({pe_grant, pe_done, pe_err, bus_read, bus_write} !== '0 || pe_rdata !== '0 || bus_addr !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got grant=%b done=%b err=%b rd=%b wr=%b rdata=%h addr=%h, required 0",
                     pe_grant, pe_done, pe_err, bus_read, bus_write, pe_rdata, bus_addr);
        end
        repeat (2) tick();
        reset = 1'b0;
        model_rdata = '0;
        set_pe(1, 32'h610, 32'h0);
        set_pe(3, 32'h630, 32'h0);
        push_exp(1, 1'b0, 1'b1, 32'h61);
        push_exp(3, 1'b0, 1'b1, 32'h63);
        for (int c = 0; c < 40 && n_done < 2; c++) begin
            tick();
            bus_ack   = bus_read;
            bus_rdata = pe_grant[1] ? 32'h61 : 32'h63;
            if (pe_done !== '0) begin
                pe_read = pe_read & ~pe_done;
                n_done++;
            end
        end
        bus_ack = 1'b0;
        n_checks++;
        if (n_done != 2) begin
            n_fail++;
            $display("FAIL after_reset: got %0d completions, required 2", n_done);
        end
        $display("reset mid-wait: completions after release=%0d", n_done);
        check_drained("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_writes();
        test_fairness();
        test_timeout();
        test_ack_last_and_both();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
